// File: rtl/stream_mux_pkg.sv
// Shared arbitration helpers for the stream muxes and arbiters in this directory.
package stream_mux_pkg;

  localparam int RR_MAX_CH = 64;
  localparam int RR_IDX_W  = $clog2(RR_MAX_CH);

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[0 +: n], searching from ptr+1 upward with wrap at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                       input int ptr, input int n);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 1; k <= RR_MAX_CH; k++) begin
      if (k <= n && !r.found) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (valid[c[RR_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N_CH requests; pointer advances only on an accepted grant.
// STREAM_MUX_RR_FIXED_PRIO_EN pins the pointer so the lowest valid index always wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            accept,
  output logic            gnt_vld,
  output logic [CH_W-1:0] gnt
);

  logic [CH_W-1:0]      ptr;
  logic [RR_MAX_CH-1:0] req_ext;
  rr_pick_t             pick;

`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
  // Pointer parked on the last channel makes the search start at ch0 every time.
  assign ptr = CH_W'(N_CH - 1);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= CH_W'(N_CH - 1);
    else if (accept && gnt_vld) ptr <= gnt;
  end
`endif

  always_comb begin
    req_ext           = '0;
    req_ext[N_CH-1:0] = req;
  end

  assign pick = rr_pick(req_ext, int'(ptr), N_CH);

  // Range guard keeps a non-power-of-2 channel count from ever granting a phantom index.
  assign gnt_vld = pick.found && (pick.idx < RR_IDX_W'(N_CH));
  assign gnt     = pick.idx[CH_W-1:0];

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration and one registered output stage.
// STREAM_MUX_RR_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_valid,
  input  logic [W-1:0]    in_data [N_CH],
  output logic [N_CH-1:0] in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CH_W-1:0] out_ch,
  input  logic            out_ready
);

  logic            can_load;
  logic            load;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt;

  assign can_load = !out_valid || out_ready;
  // Reset gates the accept so no producer sees a handshake while the stage is held clear.
  assign load     = rst_n && can_load && gnt_vld;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .accept  (load),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  always_comb begin
    in_ready = '0;
    if (load) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt];
      out_ch    <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized + directed bench for stream_mux_rr (N_CH=4 and N_CH=3 instances) against a cyclic-priority model.
module tb_stream_mux_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] v4;
  logic [7:0] d4 [4];
  logic       r4;
  logic [3:0] rdy4;
  logic       ov4;
  logic [7:0] od4;
  logic [1:0] oc4;

  logic [2:0] v3;
  logic [7:0] d3 [3];
  logic       r3;
  logic [2:0] rdy3;
  logic       ov3;
  logic [7:0] od3;
  logic [1:0] oc3;

  stream_mux_rr #(.N_CH(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(r4));

  stream_mux_rr #(.N_CH(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(r3));

  int n_chk = 0;
  int n_fail = 0;

  // model: output register contents plus the channel served last
  int   m_last [2];
  bit   m_vld  [2];
  int   m_data [2];
  int   m_ch   [2];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Winner is the first valid channel after the last served one, cyclically.
  function automatic int pick(input logic [31:0] v, input int last, input int n);
`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
    for (int c = 0; c < n; c++) if (v[c]) return c;
`else
    for (int off = 1; off <= n; off++) if (v[(last + off) % n]) return (last + off) % n;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_last[0] = 3; m_last[1] = 2;
    for (int k = 0; k < 2; k++) begin m_vld[k] = 0; m_data[k] = 0; m_ch[k] = 0; end
  endtask

  task automatic randomize_inputs();
    v4 = 4'($urandom); r4 = ($urandom_range(3) != 0);
    v3 = 3'($urandom); r3 = ($urandom_range(3) != 0);
    for (int i = 0; i < 4; i++) d4[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) d3[i] = 8'($urandom);
  endtask

  // Called right after a negedge with inputs set; ends at the following negedge.
  task automatic step();
    int g, n, ex;
    bit can, rdy;
    logic [31:0] vv;
    #1;
    for (int k = 0; k < 2; k++) begin
      n   = (k == 0) ? 4 : 3;
      vv  = (k == 0) ? 32'(v4) : 32'(v3);
      rdy = (k == 0) ? r4 : r3;
      can = !m_vld[k] || rdy;
      g   = pick(vv, m_last[k], n);
      ex  = (rst_n && can && g >= 0) ? (1 << g) : 0;
      chk(k == 0 ? "in_ready4" : "in_ready3", k == 0 ? int'(rdy4) : int'(rdy3), ex);
      if (rst_n && can && g >= 0) begin
        m_vld[k]  = 1;
        m_data[k] = (k == 0) ? int'(d4[g]) : int'(d3[g]);
        m_ch[k]   = g;
        m_last[k] = g;
      end else if (rst_n && rdy) begin
        m_vld[k] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid4", int'(ov4), int'(m_vld[0]));
    chk("out_data4",  int'(od4), m_data[0]);
    chk("out_ch4",    int'(oc4), m_ch[0]);
    chk("out_valid3", int'(ov3), int'(m_vld[1]));
    chk("out_data3",  int'(od3), m_data[1]);
    chk("out_ch3",    int'(oc3), m_ch[1]);
    chk("out_ch3_range", int'(oc3 < 2'd3), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      #1;
      chk("rst_out_valid", int'(ov4), 0);
      chk("rst_out_data",  int'(od4), 0);
      chk("rst_out_ch",    int'(oc4), 0);
      chk("rst_in_ready4", int'(rdy4), 0);
      chk("rst_in_ready3", int'(rdy3), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    v4 = '0; v3 = '0; r4 = 1'b1; r3 = 1'b1;
  endtask

  initial begin
    int exp_ch;
    v4 = '0; v3 = '0; r4 = 1'b1; r3 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = '0;
    for (int i = 0; i < 3; i++) d3[i] = '0;
    @(negedge clk);
    do_reset();

    // single channel: only ch2 valid
    v4 = 4'b0100; d4[2] = 8'hA5; r4 = 1'b1;
    #1 chk("single_in_ready", int'(rdy4), 4);
    step();
    chk("single_out_data", int'(od4), 8'hA5);
    chk("single_out_ch", int'(oc4), 2);

    // rotation from reset
    do_reset();
    v4 = 4'hF; r4 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++) begin
      step();
`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = i % 4;
`endif
      chk("rot_ch", int'(oc4), exp_ch);
      chk("rot_data", int'(od4), 8'h10 + exp_ch);
    end

    // backpressure after serving ch1
    do_reset();
    v4 = 4'b0010; d4[1] = 8'h3C; r4 = 1'b1;
    step();
    v4 = 4'hF; r4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", int'(ov4), 1);
      chk("bp_data", int'(od4), 8'h3C);
      chk("bp_ready", int'(rdy4), 0);
    end
    r4 = 1'b1;
    step();
`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
    chk("bp_next_ch", int'(oc4), 0);
`else
    chk("bp_next_ch", int'(oc4), 2);
`endif

    // wrap on the 3-channel instance: serve ch2, then ch0+ch2 -> ch0
    do_reset();
    v3 = 3'b100; r3 = 1'b1;
    step();
    v3 = 3'b101;
    step();
    chk("wrap3_ch", int'(oc3), 0);

    // reset while out_valid=1 and stalled
    v4 = 4'hF; r4 = 1'b0;
    step();
    chk("mid_valid_pre", int'(ov4), 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_valid_async", int'(ov4), 0);
    chk("mid_data_async", int'(od4), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 4'hF; r4 = 1'b1;
    step();
    chk("mid_first_ch", int'(oc4), 0);

    // ch0 and ch3 continuously valid
    do_reset();
    v4 = 4'b1001; r4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = (i % 2 == 0) ? 0 : 3;
`endif
      chk("prio_ch", int'(oc4), exp_ch);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
